usb_fifo_reader: RTL and testbench

Host-to-FPGA receive path for the FT232H/FT245 asynchronous parallel FIFO: watches `rxf_n`, strobes `rd_n`, captures each host byte from the shared data bus and hands it downstream on a valid/ready interface. It is the read-side counterpart to the existing write driver. The two share the 8-bit pad bus half-duplex, arbitrated through `wr_active`/`rd_busy`. It feeds the oscilloscope command decoder (trigger level, timebase, arm).

---
 rtl/usb_fifo_reader_pkg.sv | 16 +
 rtl/usb_fifo_reader_if.sv | 24 ++
 rtl/usb_fifo_reader_sync.sv | 24 ++
 rtl/usb_fifo_reader.sv | 90 +++++++++
 tb/tb_usb_fifo_reader.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/usb_fifo_reader_pkg.sv
// usb_fifo_pkg: shared types and timing defaults for the FT232H/FT245 FIFO read and write paths.
package usb_fifo_pkg;

    localparam int USB_DATA_W    = 8;
    localparam int T_RD_LOW_CYC  = 4;
    localparam int T_RD_HIGH_CYC = 4;

    typedef enum logic [1:0] {IDLE, STROBE, RECOVER} rd_state_t;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/usb_fifo_reader_if.sv
// usb_fifo_reader_if: pad-side FIFO signals, bus arbitration and downstream valid/ready stream.
interface usb_fifo_reader_if;
    import usb_fifo_pkg::*;

    logic                  rxf_n;
    logic [USB_DATA_W-1:0] data_in;
    logic                  wr_active;
    logic                  rd_n;
    logic                  rd_busy;
    logic [USB_DATA_W-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  rxf_n, data_in, wr_active, out_ready,
        output rd_n, rd_busy, out_data, out_valid
    );

    modport slave (
        output rxf_n, data_in, wr_active, out_ready,
        input  rd_n, rd_busy, out_data, out_valid
    );

endinterface

// File: rtl/usb_fifo_reader_sync.sv
// bit_synchronizer: multi-flop synchronizer for an asynchronous active-low status pin, resets to 1.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync[0] <= i_d;
            for (int k = 1; k < STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/usb_fifo_reader.sv
// usb_fifo_reader: strobes rd_n while the FT232H has data, captures each byte into a
// single-entry slot and hands it downstream; shares the pad bus with the write driver.
module usb_fifo_reader
    import usb_fifo_pkg::*;
#(
    parameter int RD_LOW_CYCLES  = T_RD_LOW_CYC,
    parameter int RD_HIGH_CYCLES = T_RD_HIGH_CYC,
    parameter int SYNC_STAGES    = 2
) (
    input  logic              clk,
    input  logic              reset,
    usb_fifo_reader_if.master bus
);

    localparam int CW = cnt_width(RD_LOW_CYCLES, RD_HIGH_CYCLES);

    rd_state_t             r_state, w_state;
    logic [CW-1:0]         r_cnt, w_cnt;
    logic                  r_rd_n, w_rd_n;
    logic                  r_busy, w_busy;
    logic                  r_valid, w_valid;
    logic [USB_DATA_W-1:0] r_data, w_data;
    logic                  w_rxf_s, w_start;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_rxf_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (bus.rxf_n),
        .o_q   (w_rxf_s)
    );

    assign w_start = !w_rxf_s && !bus.wr_active && (!r_valid || bus.out_ready);

    // The end of recovery re-evaluates the start condition directly so back-to-back
    // bytes keep rd_n high for exactly RD_HIGH_CYCLES clocks.
    always_comb begin
        w_state = r_state;
        w_cnt   = (r_state == IDLE) ? '0 : r_cnt + CW'(1);
        w_rd_n  = r_rd_n;
        w_busy  = r_busy;
        w_data  = r_data;
        w_valid = r_valid && !bus.out_ready;
        case (r_state)
            IDLE: if (w_start) begin
                w_state = STROBE;
                w_rd_n  = 1'b0;
                w_busy  = 1'b1;
                w_cnt   = '0;
            end
            STROBE: if (r_cnt == CW'(RD_LOW_CYCLES - 1)) begin
                w_state = RECOVER;
                w_rd_n  = 1'b1;
                w_cnt   = '0;
                w_data  = bus.data_in;
                w_valid = 1'b1;
            end
            RECOVER: if (r_cnt == CW'(RD_HIGH_CYCLES - 1)) begin
                w_state = w_start ? STROBE : IDLE;
                w_rd_n  = !w_start;
                w_busy  = w_start;
                w_cnt   = '0;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rd_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_rd_n  <= w_rd_n;
            r_busy  <= w_busy;
            r_valid <= w_valid;
            r_data  <= w_data;
        end
    end

    assign bus.rd_n      = r_rd_n;
    assign bus.rd_busy   = r_busy;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;

endmodule

// File: tb/tb_usb_fifo_reader.sv
// tb_usb_fifo_reader: directed checks of strobe timing, burst order, backpressure,
// bus arbitration and asynchronous reset for usb_fifo_reader.
module tb_usb_fifo_reader;

    logic       clk = 1'b0;
    logic       reset;
    int         total = 0;
    int         bad = 0;
    int         first, lows, busyc, vals, idx, nstr, rx, prev_fall;
    logic       prev_rd;
    logic [7:0] got;

    usb_fifo_reader_if bus ();

    usb_fifo_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.rxf_n = 1'b1;
        bus.data_in = 8'h00;
        bus.wr_active = 1'b0;
        bus.out_ready = 1'b1;
        #3;
        check("reset_rd_n", bus.rd_n, 1);
        check("reset_busy", bus.rd_busy, 0);
        check("reset_valid", bus.out_valid, 0);
        check("reset_data", bus.out_data, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // single byte
        bus.rxf_n = 1'b0;
        bus.data_in = 8'hA5;
        first = -1; lows = 0; busyc = 0; vals = 0; got = 8'h00;
        for (int e = 0; e < 24; e++) begin
            tick;
            if (!bus.rd_n) begin
                lows++;
                if (first < 0) first = e;
            end
            if (bus.rd_busy) busyc++;
            if (bus.out_valid) begin
                vals++;
                got = bus.out_data;
            end
            if (e == 6) begin
                bus.rxf_n = 1'b1;
                bus.data_in = 8'hFF;
            end
        end
        check("single_first_low_edge", first, 2);
        check("single_low_cycles", lows, 4);
        check("single_busy_cycles", busyc, 8);
        check("single_valid_cycles", vals, 1);
        check("single_data", got, 8'hA5);

        // burst of 16 bytes
        @(negedge clk);
        bus.data_in = 8'h01;
        bus.rxf_n = 1'b0;
        idx = 0; nstr = 0; rx = 0; prev_rd = 1'b1; prev_fall = -1;
        for (int c = 0; c < 200; c++) begin
            tick;
            if (prev_rd && !bus.rd_n) begin
                nstr++;
                if (prev_fall >= 0) check("burst_spacing", c - prev_fall, 8);
                prev_fall = c;
            end
            if (!prev_rd && bus.rd_n) begin
                idx++;
                if (idx == 16) bus.rxf_n = 1'b1;
                else bus.data_in = 8'(idx + 1);
            end
            if (bus.out_valid) begin
                rx++;
                check("burst_byte", bus.out_data, rx);
            end
            prev_rd = bus.rd_n;
        end
        check("burst_strobes", nstr, 16);
        check("burst_received", rx, 16);

        // backpressure
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.data_in = 8'h3C;
        bus.rxf_n = 1'b0;
        nstr = 0; prev_rd = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick;
            if (prev_rd && !bus.rd_n) nstr++;
            if (!prev_rd && bus.rd_n) bus.data_in = 8'h77;
            prev_rd = bus.rd_n;
        end
        check("bp_strobes", nstr, 1);
        check("bp_valid_held", bus.out_valid, 1);
        check("bp_data_held", bus.out_data, 8'h3C);
        check("bp_rd_n_high", bus.rd_n, 1);
        check("bp_busy_low", bus.rd_busy, 0);
        @(negedge clk);
        bus.out_ready = 1'b1;
        tick;
        check("bp_restart_rd_n", bus.rd_n, 0);
        check("bp_consumed", bus.out_valid, 0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (4) tick;
        check("bp_second_valid", bus.out_valid, 1);
        check("bp_second_data", bus.out_data, 8'h77);
        check("bp_second_rd_n", bus.rd_n, 1);
        bus.rxf_n = 1'b1;
        repeat (6) tick;
        @(negedge clk);
        bus.out_ready = 1'b1;
        tick;
        check("bp_drain_valid", bus.out_valid, 0);
        lows = 0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (!bus.rd_n) lows++;
        end
        check("bp_no_extra_strobe", lows, 0);

        // bus arbitration
        @(negedge clk);
        bus.wr_active = 1'b1;
        bus.data_in = 8'h5A;
        bus.rxf_n = 1'b0;
        lows = 0; busyc = 0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (!bus.rd_n) lows++;
            if (bus.rd_busy) busyc++;
        end
        check("arb_hold_rd_n", lows, 0);
        check("arb_hold_busy", busyc, 0);
        @(negedge clk);
        bus.wr_active = 1'b0;
        tick;
        check("arb_rd_n_falls", bus.rd_n, 0);
        check("arb_busy_rises", bus.rd_busy, 1);
        lows = 1; busyc = 1; got = 8'h00;
        for (int c = 1; c < 16; c++) begin
            tick;
            if (c == 2) bus.wr_active = 1'b1;
            if (!bus.rd_n) lows++;
            if (bus.rd_busy) busyc++;
            if (bus.out_valid) got = bus.out_data;
            if (c == 4) bus.rxf_n = 1'b1;
        end
        check("arb_low_cycles", lows, 4);
        check("arb_busy_cycles", busyc, 8);
        check("arb_data", got, 8'h5A);
        @(negedge clk);
        bus.wr_active = 1'b0;

        // reset mid-strobe
        @(negedge clk);
        bus.data_in = 8'hC3;
        bus.rxf_n = 1'b0;
        first = -1;
        for (int c = 0; c < 10 && first < 0; c++) begin
            tick;
            if (!bus.rd_n) first = c;
        end
        check("rst_strobe_start", first, 2);
        tick;
        tick;
        #5;
        reset = 1'b1;
        #1;
        check("rst_async_rd_n", bus.rd_n, 1);
        check("rst_async_valid", bus.out_valid, 0);
        check("rst_async_busy", bus.rd_busy, 0);
        check("rst_async_data", bus.out_data, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        first = -1; got = 8'h00;
        for (int e = 0; e < 12; e++) begin
            tick;
            if (!bus.rd_n && first < 0) first = e;
            if (bus.out_valid) got = bus.out_data;
            if (e == 6) bus.rxf_n = 1'b1;
        end
        check("rst_resume_first_low", first, 2);
        check("rst_resume_data", got, 8'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
